// File: rtl/program_loader_if.sv
// program_loader_if: byte-stream load link plus CPU memory read port and release status.
interface program_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              rx_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_val;
  logic              cpu_rst;
  logic              load_done;
  logic              load_err;
  modport master (
    output rx_valid, rx_data, mem_addr,
    input  rx_ready, mem_val, cpu_rst, load_done, load_err
  );
  modport slave (
    input  rx_valid, rx_data, mem_addr,
    output rx_ready, mem_val, cpu_rst, load_done, load_err
  );
endinterface

// File: rtl/program_loader.sv
// program_loader: streams a length-prefixed program into RAM, then releases the CPU and serves reads.
// Define PROGRAM_LOADER_CHECKSUM_EN to require a trailing mod-2^DATA_W checksum byte before release.
module program_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input logic clk,
  input logic rst,
  program_loader_if.slave bus
);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {LEN, DATA, CHK, RUN, ERR} state_e;
  logic [DATA_W-1:0] sum_q;
  logic              load_err_q;
`else
  typedef enum logic [1:0] {LEN, DATA, RUN} state_e;
`endif
  state_e            state_q;
  logic [ADDR_W:0]   count_q, count_d, len_q, len_d;
  logic              rx_ready_q, cpu_rst_q, load_done_q, xfer;
  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  assign xfer    = bus.rx_valid & rx_ready_q;
  assign count_d = count_q + (ADDR_W+1)'(1);
  // A zero length byte stands for a full-depth image.
  assign len_d   = (bus.rx_data == '0) ? {1'b1, {ADDR_W{1'b0}}} : (ADDR_W+1)'(bus.rx_data);
  always_ff @(posedge clk) begin
    if (rst && xfer && state_q == DATA) mem_q[count_q[ADDR_W-1:0]] <= bus.rx_data;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= LEN;
      count_q     <= '0;
      len_q       <= '0;
      rx_ready_q  <= 1'b1;
      cpu_rst_q   <= 1'b0;
      load_done_q <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum_q       <= '0;
      load_err_q  <= 1'b0;
`endif
    end else if (xfer) begin
      case (state_q)
        LEN: begin
          len_q   <= len_d;
          count_q <= '0;
          state_q <= DATA;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          sum_q   <= '0;
`endif
        end
        DATA: begin
          count_q <= count_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          sum_q <= sum_q + bus.rx_data;
          if (count_d == len_q) state_q <= CHK;
`else
          if (count_d == len_q) begin
            state_q     <= RUN;
            rx_ready_q  <= 1'b0;
            cpu_rst_q   <= 1'b1;
            load_done_q <= 1'b1;
          end
`endif
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        CHK: begin
          state_q     <= (bus.rx_data == sum_q) ? RUN : ERR;
          rx_ready_q  <= 1'b0;
          cpu_rst_q   <= (bus.rx_data == sum_q);
          load_done_q <= (bus.rx_data == sum_q);
          load_err_q  <= (bus.rx_data != sum_q);
        end
`endif
        default: ;
      endcase
    end
  end
  assign bus.rx_ready  = rx_ready_q;
  assign bus.cpu_rst   = cpu_rst_q;
  assign bus.load_done = load_done_q;
  assign bus.mem_val   = load_done_q ? mem_q[bus.mem_addr] : '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  assign bus.load_err  = load_err_q;
`else
  assign bus.load_err  = 1'b0;
`endif
endmodule

// File: doc/program_loader.md
# program_loader

Boot-time program store sitting directly upstream of the CPU's memory port: it receives a program as a byte stream over a valid/ready link, writes it into an internal 2^ADDR_W-byte RAM, then releases the CPU from reset and serves instruction/data bytes on `memVal` for the CPU-driven `memAddr`. While loading, the CPU is held in reset and `memVal` reads as zero. An optional trailing checksum gates release of the CPU.

## Interface
- `ADDR_W`, 8: address width; RAM depth is 2^ADDR_W; must match CPU `memAddr` width.
- `DATA_W`, 8: byte width of stream and RAM words.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-low reset (sampled on rising `clk`; low = reset).
- `rxValid`  in  1  stream byte valid.
- `rxData`  in  DATA_W  stream byte.
- `rxReady`  out  1  loader can accept a byte; transfer = `rxValid & rxReady` at rising edge.
- `memAddr`  in  ADDR_W  read address from CPU.
- `memVal`  out  DATA_W  read data to CPU.
- `cpuRst`  out  1  active-low reset to CPU; low holds CPU in reset.
- `loadDone`  out  1  high in RUN.
- `loadErr`  out  1  high in ERR (checksum build only; tied 0 otherwise).

## Operation
- States: LEN, DATA, CHK (checksum build only), RUN, ERR. Reset state: LEN.
- Reset values: state=LEN, count=0, sum=0, `rxReady`=1, `cpuRst`=0, `loadDone`=0, `loadErr`=0, `memVal`=0. RAM contents not cleared by reset.
- LEN: on transfer, latch `rxData` as length N; N=0 means 2^ADDR_W bytes. count←0, sum←0, go DATA.
- DATA: on transfer, RAM[count]←`rxData`, sum←(sum+`rxData`) mod 2^DATA_W, count←count+1. After the Nth byte: go CHK if compiled in, else RUN. Count is ADDR_W+1 bits internally so N=2^ADDR_W terminates correctly; write address is count[ADDR_W-1:0].
- CHK: on transfer, compare `rxData` with sum; equal → RUN, unequal → ERR.
- RUN: `rxReady`=0; `rxValid`/`rxData` ignored; `cpuRst`=1; `loadDone`=1; `memVal`=RAM[`memAddr`] combinationally (asynchronous read).
- ERR: `rxReady`=0, `cpuRst`=0, `loadErr`=1, `memVal`=0; exit only via `rst`.
- Outside RUN, `memVal`=0 regardless of `memAddr`.
- Addresses ≥N keep prior RAM contents (no clear).
- Reset mid-load: next edge returns to LEN with count/sum cleared; partially written bytes remain in RAM; `cpuRst` low.
- Reset in RUN: CPU re-held in reset; a full new stream (length first) is required.

## Timing
- `rxReady` is a registered state decode: high in LEN/DATA/CHK, including the cycle after each transfer (one byte per cycle sustained).
- RAM write occurs on the transfer edge; byte is readable only in RUN.
- RUN/ERR entered on the edge accepting the final byte (last data byte or checksum); `cpuRst`, `loadDone`, `loadErr`, `rxReady` change on that same edge (registered outputs).
- `memVal` in RUN: zero-cycle combinational from `memAddr`.
- `rxValid` low: no state change; holding `rxData` not required.

## Configuration
- `PROGRAM_LOADER_CHECKSUM_EN` defined: CHK state present; one checksum byte (8-bit mod-256 sum of the N data bytes) follows data; mismatch → ERR, CPU never released.
- Not defined: no CHK/ERR states; RUN entered after the Nth data byte; `loadErr` tied 0; sum logic removed.

## Test plan
- Basic load: reset, stream 03,11,22,33 (+checksum 66 if enabled) -> `cpuRst`/`loadDone` rise on final-byte edge; `memAddr`=0,1,2 gives `memVal`=11,22,33; `rxReady`=0.
- Gated stream: same bytes with `rxValid` dropped 2 cycles between each -> identical RAM and release; no extra writes.
- Full depth: length 00 followed by 256 bytes i=0..255 -> RUN only after 256th byte; `memVal`=`memAddr` for all 256 addresses.
- Checksum error (enabled build): 02,05,06, checksum 0A -> `loadErr`=1, `cpuRst`=0, `memVal`=0; checksum 0B in a retry after `rst` -> RUN.
- Reset mid-load: 04,AA,BB then `rst` low one cycle, then 01,CC -> RUN after CC; `memAddr`=0 gives CC, `memAddr`=1 gives BB.
- Post-load traffic: in RUN drive `rxValid`=1, `rxData`=FF for 10 cycles -> RAM, `memVal`, and state unchanged.
